kd_level_stage: RTL and testbench
=================================

// Module: kd_level_stage
// PURPOSE
//  One pipelined level of the KD-tree traversal datapath. Holds the split entries of every node at
//  tree depth LEVEL in a small register table. Steers each incoming patch to the left or right child
//  and forwards the patch with its extended node path to the next level.
//  Stages chain as level0 -> level1 -> ... -> leaf lookup. Valid/ready handshake with a 2-entry skid buffer.
// PARAMETERS
//  DATA_WIDTH     55  patch width = NUM_DIMS * COMP_WIDTH
//  COMP_WIDTH     11  unsigned width of one patch component / split value
//  NUM_DIMS       5   components per patch
//  STORAGE_WIDTH  22  node entry width = {split[COMP_WIDTH-1:0], dim_idx[COMP_WIDTH-1:0]}
//  LEVEL          2   tree depth; table holds 2**LEVEL entries; LW = (LEVEL==0) ? 1 : LEVEL
// PORTS
//  clk        in   1              clock, all logic on rising edge
//  rst        in   1              synchronous reset, active-high
//  cfg_wen    in   1              write node entry
//  cfg_waddr  in   LW             node index within this level (ignored when LEVEL==0)
//  cfg_wdata  in   STORAGE_WIDTH  {split, dim_idx}
//  in_valid   in   1              upstream patch valid
//  in_ready   out  1              stage can accept
//  in_patch   in   DATA_WIDTH     component k = in_patch[k*COMP_WIDTH +: COMP_WIDTH]
//  in_node    in   LW             path so far (node index at this level); ignored when LEVEL==0
//  out_valid  out  1              result valid
//  out_ready  in   1              downstream accepts
//  out_patch  out  DATA_WIDTH     patch, unchanged
//  out_node   out  LEVEL+1        {in_node, dir} (LEVEL==0: {dir})
//  out_dir    out  1              0 = left, 1 = right
//  cfg_err    out  1              sticky: a patch used an entry with dim_idx >= NUM_DIMS
// BEHAVIOUR
//  - Reset: table entries cleared to 0; skid buffer emptied.
//    Outputs after reset: out_valid=0, out_patch=0, out_node=0, out_dir=0, cfg_err=0, in_ready=1.
//  - Decision (combinational on input side):
//    e = table[in_node]; c = component e.dim_idx of in_patch.
//    dir = (c < e.split) ? 0 : 1, unsigned compare; equality goes right.
//  - Bad dim_idx: if e.dim_idx >= NUM_DIMS, dir=1 and cfg_err is set on acceptance; it holds until rst.
//  - Transfer: a beat moves when in_valid & in_ready (input) or out_valid & out_ready (output).
//  - Latency: an accepted beat appears on the out_* ports the next cycle when the stage was empty.
//    Throughput is 1 beat/cycle while out_ready=1.
//  - Skid buffer: 2 entries, out_* driven from the head entry. in_ready = (occupancy < 2), registered.
//    Occupancy 2 -> in_ready=0 -> no accept.
//    Accept and output transfer in the same cycle: occupancy unchanged, FIFO order kept.
//    Outputs hold stable while out_valid=1 and out_ready=0.
//  - Config write: visible to decisions from the next cycle.
//    cfg_wen in the same cycle as an accept on the same node: decision uses the OLD entry.
//    Results already computed are never re-evaluated.
//  - Reset mid-traffic: buffered beats are discarded; out_valid=0 the cycle after rst is sampled high.
//  - in_patch / in_node are ignored when in_valid=0. Accepts while in_ready=0 are illegal upstream behaviour.
// TESTING
//  1. LEVEL=0: write {split=2, dim=1}.
//     Patch with comp1=1, others 3 -> next cycle out_valid=1, out_dir=0, out_node=1'b0.
//     Comp1=3 -> out_dir=1.
//  2. Equality: split=4, dim=0, comp0=4 -> out_dir=1. Comp0=2047 with split=4 -> out_dir=1.
//     Comp0=0 with split=1 -> out_dir=0.
//  3. LEVEL=2, nodes 0..3 given distinct splits. Stream 4 back-to-back patches with in_node 0..3
//     -> out_node={in_node, dir} in order, one per cycle, no bubbles.
//  4. Backpressure: hold out_ready=0, send 3 beats.
//     -> in_ready drops after 2 accepts, out_* stable.
//     Release out_ready -> both beats drain in order, then in_ready=1.
//  5. Write entry dim=7 -> patch accepted -> out_dir=1, cfg_err=1, which persists until rst.
//     Same-cycle cfg_wen and accept -> old split used.
//  6. Assert rst with 2 beats buffered -> next cycle out_valid=0, in_ready=1, cfg_err=0.
//     Table zeroed: split=0 -> any patch routes right.

Source files
------------

// File: rtl/kd_level_stage.sv
// ---------------------------------------------------------------------------
// kd_level_stage
//   One pipelined level of the KD-tree traversal datapath. A small register
//   table holds the {split, dim_idx} entry of every node at depth LEVEL.
//   Each accepted patch is steered left (0) or right (1) by comparing one of
//   its components against the node's split value. The patch is forwarded
//   with its node path extended by the direction bit. A 2-entry skid buffer
//   decouples the upstream and downstream valid/ready handshakes.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   cfg_wen/waddr/wdata      node table write port ({split, dim_idx})
//   in_valid/in_ready        upstream handshake
//   in_patch/in_node         patch and node path so far
//   out_valid/out_ready      downstream handshake
//   out_patch/out_node       patch (unchanged) and extended path {in_node, dir}
//   out_dir                  steering decision, 0 = left, 1 = right
//   cfg_err                  sticky flag: a patch used an entry with a bad dim_idx
// ---------------------------------------------------------------------------
module kd_level_stage #(
    parameter int DATA_WIDTH    = 55,
    parameter int COMP_WIDTH    = 11,
    parameter int NUM_DIMS      = 5,
    parameter int STORAGE_WIDTH = 22,
    parameter int LEVEL         = 2,
    localparam int LW           = (LEVEL == 0) ? 1 : LEVEL
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_wen,
    input  logic [LW-1:0]            cfg_waddr,
    input  logic [STORAGE_WIDTH-1:0] cfg_wdata,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    in_patch,
    input  logic [LW-1:0]            in_node,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_patch,
    output logic [LEVEL:0]           out_node,
    output logic                     out_dir,
    output logic                     cfg_err
);

    localparam int DEPTH = 1 << LEVEL;
    localparam int NW    = LEVEL + 1;
    localparam int SW    = DATA_WIDTH + NW + 1;
    localparam logic [COMP_WIDTH-1:0] NUM_DIMS_C = COMP_WIDTH'(NUM_DIMS);

    // ---------------- node table ----------------
    logic [STORAGE_WIDTH-1:0] table_q [DEPTH];
    logic [STORAGE_WIDTH-1:0] table_d [DEPTH];
    logic [LW-1:0]            wr_idx;
    logic [LW-1:0]            rd_idx;

    // A single-node level has no address: both indices collapse to entry 0.
    generate
        if (LEVEL == 0) begin : g_idx_root
            assign wr_idx = '0;
            assign rd_idx = '0;
        end else begin : g_idx_inner
            assign wr_idx = cfg_waddr;
            assign rd_idx = in_node;
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            table_d[i] = table_q[i];
        end
        if (cfg_wen) begin
            table_d[wr_idx] = cfg_wdata;
        end
    end

    // ---------------- decision ----------------
    logic [COMP_WIDTH-1:0] comps [NUM_DIMS];
    logic [STORAGE_WIDTH-1:0] entry;
    logic [COMP_WIDTH-1:0] split_val;
    logic [COMP_WIDTH-1:0] dim_idx;
    logic [COMP_WIDTH-1:0] comp_sel;
    logic                  bad_dim;
    logic                  dir;
    logic [NW-1:0]         new_node;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIMS; gi++) begin : g_comp
            assign comps[gi] = in_patch[gi*COMP_WIDTH +: COMP_WIDTH];
        end
    endgenerate

    // The table is read before this cycle's write lands, so a same-cycle
    // config write never affects the beat being accepted.
    assign entry     = table_q[rd_idx];
    assign split_val = entry[STORAGE_WIDTH-1 -: COMP_WIDTH];
    assign dim_idx   = entry[COMP_WIDTH-1:0];

    always_comb begin
        comp_sel = '0;
        for (int k = 0; k < NUM_DIMS; k++) begin
            if (dim_idx == COMP_WIDTH'(k)) begin
                comp_sel = comps[k];
            end
        end
    end

    assign bad_dim = (dim_idx >= NUM_DIMS_C);
    // Equality routes right; an out-of-range dimension also routes right.
    assign dir     = bad_dim | (comp_sel >= split_val);

    generate
        if (LEVEL == 0) begin : g_node_root
            assign new_node = dir;
        end else begin : g_node_inner
            assign new_node = {in_node, dir};
        end
    endgenerate

    // ---------------- skid buffer ----------------
    // slot0 is always the head; a pop with two entries shifts slot1 down.
    logic [SW-1:0] slot0_q, slot0_d;
    logic [SW-1:0] slot1_q, slot1_d;
    logic [1:0]    count_q, count_d;
    logic          in_ready_q, in_ready_d;
    logic          cfg_err_q, cfg_err_d;
    logic          push;
    logic          pop;
    logic [SW-1:0] new_beat;

    assign new_beat = {in_patch, new_node, dir};
    assign push     = in_valid & in_ready_q;
    assign pop      = (count_q != 2'd0) & out_ready;

    always_comb begin
        slot0_d   = slot0_q;
        slot1_d   = slot1_q;
        count_d   = count_q;
        cfg_err_d = cfg_err_q | (push & bad_dim);
        case (count_q)
            2'd0: begin
                if (push) begin
                    slot0_d = new_beat;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    slot0_d = new_beat;
                end else if (push) begin
                    slot1_d = new_beat;
                    count_d = 2'd2;
                end else if (pop) begin
                    count_d = 2'd0;
                end
            end
            2'd2: begin
                // in_ready is low when full, so only a pop can happen here.
                if (pop) begin
                    slot0_d = slot1_q;
                    count_d = 2'd1;
                end
            end
            default: count_d = 2'd0;
        endcase
        in_ready_d = (count_d != 2'd2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= '0;
            end
            slot0_q    <= '0;
            slot1_q    <= '0;
            count_q    <= 2'd0;
            in_ready_q <= 1'b1;
            cfg_err_q  <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= table_d[i];
            end
            slot0_q    <= slot0_d;
            slot1_q    <= slot1_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (count_q != 2'd0);
    assign {out_patch, out_node, out_dir} = slot0_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_kd_level_stage.sv
module tb_kd_level_stage;

    localparam int DW  = 55;
    localparam int CW  = 11;
    localparam int ND  = 5;
    localparam int STW = 22;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // LEVEL=2 instance
    logic            rst, cfg_wen, in_valid, in_ready, out_valid, out_ready, out_dir, cfg_err;
    logic [1:0]      cfg_waddr, in_node;
    logic [STW-1:0]  cfg_wdata;
    logic [DW-1:0]   in_patch, out_patch;
    logic [2:0]      out_node;

    // LEVEL=0 instance
    logic            z_rst, z_wen, z_valid, z_ready, z_ovalid, z_oready, z_odir, z_err;
    logic [0:0]      z_waddr, z_node, z_onode;
    logic [STW-1:0]  z_wdata;
    logic [DW-1:0]   z_patch, z_opatch;

    kd_level_stage #(.DATA_WIDTH(DW), .COMP_WIDTH(CW), .NUM_DIMS(ND),
                     .STORAGE_WIDTH(STW), .LEVEL(2)) u_dut (
        .clk(clk), .rst(rst), .cfg_wen(cfg_wen), .cfg_waddr(cfg_waddr), .cfg_wdata(cfg_wdata),
        .in_valid(in_valid), .in_ready(in_ready), .in_patch(in_patch), .in_node(in_node),
        .out_valid(out_valid), .out_ready(out_ready), .out_patch(out_patch),
        .out_node(out_node), .out_dir(out_dir), .cfg_err(cfg_err));

    kd_level_stage #(.DATA_WIDTH(DW), .COMP_WIDTH(CW), .NUM_DIMS(ND),
                     .STORAGE_WIDTH(STW), .LEVEL(0)) u_dut0 (
        .clk(clk), .rst(z_rst), .cfg_wen(z_wen), .cfg_waddr(z_waddr), .cfg_wdata(z_wdata),
        .in_valid(z_valid), .in_ready(z_ready), .in_patch(z_patch), .in_node(z_node),
        .out_valid(z_ovalid), .out_ready(z_oready), .out_patch(z_opatch),
        .out_node(z_onode), .out_dir(z_odir), .cfg_err(z_err));

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [DW-1:0] p;
        logic [2:0]    n;
        logic          d;
    } beat_t;

    int    m_split [4];
    int    m_dim   [4];
    bit    m_err;
    beat_t q [$];

    function automatic logic [DW-1:0] mk5(int c0, int c1, int c2, int c3, int c4);
        logic [DW-1:0] p;
        p = '0;
        p[0*CW +: CW] = CW'(c0);
        p[1*CW +: CW] = CW'(c1);
        p[2*CW +: CW] = CW'(c2);
        p[3*CW +: CW] = CW'(c3);
        p[4*CW +: CW] = CW'(c4);
        return p;
    endfunction

    // Route by the node's chosen component; out-of-range dims go right.
    function automatic logic ref_dir(logic [DW-1:0] p, int node);
        int dim;
        int c;
        dim = m_dim[node];
        if (dim >= ND) return 1'b1;
        c = int'((p >> (dim * CW)) & 55'h7ff);
        return (c >= m_split[node]) ? 1'b1 : 1'b0;
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(string tag);
        check({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() != 0));
        check({tag, ".in_ready"},  64'(in_ready),  64'(q.size() < 2));
        check({tag, ".cfg_err"},   64'(cfg_err),   64'(m_err));
        if (q.size() != 0) begin
            check({tag, ".out_patch"}, 64'(out_patch), 64'(q[0].p));
            check({tag, ".out_node"},  64'(out_node),  64'(q[0].n));
            check({tag, ".out_dir"},   64'(out_dir),   64'(q[0].d));
        end
    endtask

    // One clock of the LEVEL=2 stage with the currently driven inputs.
    task automatic step(string tag);
        bit    acc;
        bit    pp;
        beat_t nb;
        int    node;
        acc  = in_valid && (q.size() < 2);
        pp   = (q.size() > 0) && out_ready;
        node = int'(in_node);
        nb.p = in_patch;
        nb.d = ref_dir(in_patch, node);
        nb.n = {in_node, nb.d};
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            for (int i = 0; i < 4; i++) begin
                m_split[i] = 0;
                m_dim[i]   = 0;
            end
            m_err = 0;
        end else begin
            if (pp) void'(q.pop_front());
            if (acc) begin
                q.push_back(nb);
                if (m_dim[node] >= ND) m_err = 1;
            end
            if (cfg_wen) begin
                m_split[int'(cfg_waddr)] = int'(cfg_wdata[21:11]);
                m_dim[int'(cfg_waddr)]   = int'(cfg_wdata[10:0]);
            end
        end
        $display("step %-10s vld=%0b node=%0d ordy=%0b wen=%0b | out_v=%0b node=%0d dir=%0b in_rdy=%0b err=%0b",
                 tag, in_valid, in_node, out_ready, cfg_wen, out_valid, out_node, out_dir, in_ready, cfg_err);
        check_state(tag);
    endtask

    task automatic set_cfg(logic wen, int addr, int split, int dim);
        cfg_wen   = wen;
        cfg_waddr = 2'(addr);
        cfg_wdata = {CW'(split), CW'(dim)};
    endtask

    task automatic set_in(logic v, logic [DW-1:0] p, int node);
        in_valid = v;
        in_patch = p;
        in_node  = 2'(node);
    endtask

    function automatic logic [DW-1:0] rnd_patch();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[DW-1:0];
    endfunction

    // LEVEL=0 helpers
    task automatic zstep();
        @(posedge clk);
        #1;
    endtask

    task automatic zwrite(int split, int dim);
        z_wen   = 1'b1;
        z_wdata = {CW'(split), CW'(dim)};
        zstep();
        z_wen   = 1'b0;
    endtask

    task automatic zsend(string tag, logic [DW-1:0] p, logic exp_dir);
        z_valid = 1'b1;
        z_patch = p;
        zstep();
        z_valid = 1'b0;
        $display("l0 %-8s out_v=%0b dir=%0b node=%0d", tag, z_ovalid, z_odir, z_onode);
        check({tag, ".l0_valid"}, 64'(z_ovalid), 64'(1'b1));
        check({tag, ".l0_dir"},   64'(z_odir),   64'(exp_dir));
        check({tag, ".l0_node"},  64'(z_onode),  64'(exp_dir));
        check({tag, ".l0_patch"}, 64'(z_opatch), 64'(p));
    endtask

    initial begin
        logic [DW-1:0] p;
        int            nd;
        int            dd;

        rst = 1'b1; set_cfg(1'b0, 0, 0, 0); set_in(1'b0, '0, 0); out_ready = 1'b1;
        z_rst = 1'b1; z_wen = 1'b0; z_waddr = '0; z_wdata = '0;
        z_valid = 1'b0; z_patch = '0; z_node = '0; z_oready = 1'b1;

        // ---- LEVEL=0: basic routing and equality ----
        zstep();
        z_rst = 1'b0;
        zstep();
        check("l0_reset.valid", 64'(z_ovalid), 64'(1'b0));
        check("l0_reset.ready", 64'(z_ready),  64'(1'b1));
        zwrite(2, 1);
        zsend("lt",   mk5(3, 1, 3, 3, 3), 1'b0);
        zsend("ge",   mk5(3, 3, 3, 3, 3), 1'b1);
        zwrite(4, 0);
        zsend("eq",   mk5(4, 0, 0, 0, 0), 1'b1);
        zsend("max",  mk5(2047, 0, 0, 0, 0), 1'b1);
        zwrite(1, 0);
        zsend("zero", mk5(0, 9, 9, 9, 9), 1'b0);
        check("l0_err", 64'(z_err), 64'(1'b0));

        // ---- LEVEL=2: reset state ----
        step("reset");
        rst = 1'b0;
        step("post_rst");
        check("rst.out_patch", 64'(out_patch), 64'(0));
        check("rst.out_node",  64'(out_node),  64'(0));
        check("rst.out_dir",   64'(out_dir),   64'(0));

        // ---- configure distinct splits ----
        for (int i = 0; i < 4; i++) begin
            set_cfg(1'b1, i, 100 + 500 * i, i);
            step("cfg");
        end
        set_cfg(1'b0, 0, 0, 0);

        // ---- back-to-back stream, nodes 0..3 ----
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, rnd_patch(), i);
            step("stream");
        end
        set_in(1'b0, '0, 0);
        step("drain");
        step("drain");

        // ---- backpressure ----
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, rnd_patch(), i);
            step("bp_send");
        end
        step("bp_hold");
        set_in(1'b0, '0, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step("bp_drain");

        // ---- random traffic ----
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0)
                set_cfg(1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 2047)),
                        int'($urandom_range(0, ND - 1)));
            else
                set_cfg(1'b0, 0, 0, 0);
            nd = int'($urandom_range(0, 3));
            p  = rnd_patch();
            if ($urandom_range(0, 3) == 0) begin
                dd = m_dim[nd];
                p[dd*CW +: CW] = CW'(m_split[nd] + int'($urandom_range(0, 2)) - 1);
            end
            set_in($urandom_range(0, 3) != 0, p, nd);
            out_ready = ($urandom_range(0, 3) != 0);
            step("random");
        end
        set_cfg(1'b0, 0, 0, 0);
        set_in(1'b0, '0, 0);
        out_ready = 1'b1;
        step("rdrain");
        step("rdrain");

        // ---- same-cycle write and accept uses the old entry ----
        set_cfg(1'b1, 2, 100, 0);
        step("old_cfg");
        set_cfg(1'b1, 2, 2000, 0);
        set_in(1'b1, mk5(500, 0, 0, 0, 0), 2);
        step("old_use");
        set_cfg(1'b0, 0, 0, 0);
        set_in(1'b1, mk5(500, 0, 0, 0, 0), 2);
        step("new_use");
        set_in(1'b0, '0, 0);
        step("drain");

        // ---- bad dim_idx sets sticky error ----
        set_cfg(1'b1, 1, 0, 7);
        step("bad_cfg");
        set_cfg(1'b0, 0, 0, 0);
        set_in(1'b1, rnd_patch(), 1);
        step("bad_use");
        set_in(1'b0, '0, 0);
        for (int i = 0; i < 3; i++) step("err_hold");

        // ---- reset mid-traffic ----
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, rnd_patch(), i);
            step("pre_rst");
        end
        set_in(1'b0, '0, 0);
        rst = 1'b1;
        step("mid_rst");
        rst = 1'b0;
        out_ready = 1'b1;
        set_in(1'b1, mk5(0, 0, 0, 0, 0), 3);
        step("zero_tbl");
        check("zero_tbl.dir", 64'(out_dir), 64'(1'b1));
        set_in(1'b0, '0, 0);
        step("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
